// File: rtl/line_buffer_wr.sv
// Line buffer write side: pixel capture into a two-page line memory,
// page swap on line end, and a measured line period.
module line_buffer_wr #(
  parameter int C_ADDR_W = 9,
  parameter int D_WIDTH  = 10
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                PULSE,
  input  logic                PIXEL_ERROR,
  input  logic [D_WIDTH-1:0]  DIN,
  input  logic                LINE_SYNC,
  input  logic                FRAME_SYNC,
  input  logic [C_ADDR_W-2:0] RD_ADDR,
  output logic [D_WIDTH-1:0]  RD_DATA,
  output logic [C_ADDR_W-1:0] DPRAM_WR_ADDR,
  output logic                DPRAM_WE,
  output logic                DPRAM_RD_PAGE,
  output logic                LINE_FINISHED,
  output logic [15:0]         LINE_PERIOD
);

  localparam int PW = C_ADDR_W - 1;

  logic [D_WIDTH-1:0] mem [2**C_ADDR_W];

  logic          wp;
  logic [PW-1:0] pc;
  logic          sat;
  logic [15:0]   cc;
  logic [15:0]   cc_inc;
  logic          valid;
  logic          take;
  logic          wr_en;
  logic          pc_last;

  // frame sync discards a coincident pixel; a full line ignores pixels
  assign take    = PULSE && !FRAME_SYNC && !sat;
  assign wr_en   = take && !PIXEL_ERROR;
  assign pc_last = (pc == '1);
  assign cc_inc  = (cc == 16'hFFFF) ? cc : cc + 16'd1;

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[{wp, pc}] <= DIN;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      DPRAM_WE      <= 1'b0;
      DPRAM_WR_ADDR <= '0;
      DPRAM_RD_PAGE <= 1'b1;
      LINE_FINISHED <= 1'b0;
      LINE_PERIOD   <= '0;
      RD_DATA       <= '0;
      wp            <= 1'b0;
      pc            <= '0;
      sat           <= 1'b0;
      cc            <= '0;
      valid         <= 1'b0;
    end else begin
      DPRAM_WE      <= wr_en;
      LINE_FINISHED <= LINE_SYNC && !FRAME_SYNC;
      RD_DATA       <= mem[{DPRAM_RD_PAGE, RD_ADDR}];
      cc            <= cc_inc;
      if (wr_en) DPRAM_WR_ADDR <= {wp, pc};
      if (FRAME_SYNC) begin
        wp            <= 1'b0;
        DPRAM_RD_PAGE <= 1'b1;
        pc            <= '0;
        sat           <= 1'b0;
        cc            <= '0;
        valid         <= 1'b0;
      end else if (LINE_SYNC) begin
        wp            <= ~wp;
        DPRAM_RD_PAGE <= wp;
        pc            <= '0;
        sat           <= 1'b0;
        cc            <= '0;
        valid         <= 1'b1;
        if (valid) LINE_PERIOD <= cc_inc;
      end else if (take) begin
        if (pc_last) sat <= 1'b1;
        else         pc  <= pc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_wr.sv
// Directed vector bench for line_buffer_wr: write path, page swap,
// readback, line period, saturation and async reset.
module tb_line_buffer_wr;

  logic       CLOCK_tb = 1'b0;
  logic       reset_n;
  logic       pulse, pixel_error, line_sync, frame_sync;
  logic [9:0] din;
  logic [7:0] rd_addr;
  logic [9:0] rd_data;
  logic [8:0] wr_addr;
  logic       we, rd_page, line_finished;
  logic [15:0] line_period;

  int n_chk = 0;
  int n_err = 0;

  line_buffer_wr #(.C_ADDR_W(9), .D_WIDTH(10)) dut (
    .CLOCK(CLOCK_tb), .RESET_N(reset_n),
    .PULSE(pulse), .PIXEL_ERROR(pixel_error), .DIN(din),
    .LINE_SYNC(line_sync), .FRAME_SYNC(frame_sync),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .DPRAM_WR_ADDR(wr_addr), .DPRAM_WE(we),
    .DPRAM_RD_PAGE(rd_page), .LINE_FINISHED(line_finished),
    .LINE_PERIOD(line_period)
  );

  always #5 CLOCK_tb = ~CLOCK_tb;

  typedef struct {
    logic        pulse, err, ls, fs;
    logic [9:0]  din;
    logic [7:0]  rd_addr;
    logic        we;
    logic [8:0]  addr;
    logic        rd_page, lf, chk_rd;
    logic [9:0]  rd;
    logic [15:0] per;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(
    logic p, logic e, logic l, logic f, logic [9:0] d, logic [7:0] ra,
    logic w, logic [8:0] a, logic rp, logic lf, logic cr,
    logic [9:0] rd, logic [15:0] per);
    vec_t v;
    v.pulse = p; v.err = e; v.ls = l; v.fs = f; v.din = d;
    v.rd_addr = ra; v.we = w; v.addr = a; v.rd_page = rp;
    v.lf = lf; v.chk_rd = cr; v.rd = rd; v.per = per;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(logic p, logic e, logic l, logic f,
                      logic [9:0] d, logic [7:0] ra);
    @(negedge CLOCK_tb);
    pulse = p; pixel_error = e; line_sync = l; frame_sync = f;
    din = d; rd_addr = ra;
    @(posedge CLOCK_tb);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    pulse = 0; pixel_error = 0; line_sync = 0; frame_sync = 0;
    din = '0; rd_addr = '0;

    //        p  e  l  f  din     ra  we addr  rp lf cr rd      per
    vt[0]  = mk(1, 0, 0, 0, 10'h101, 0, 1, 9'd0,   1, 0, 0, 10'h0,   0);
    vt[1]  = mk(1, 0, 0, 0, 10'h102, 0, 1, 9'd1,   1, 0, 0, 10'h0,   0);
    vt[2]  = mk(1, 0, 0, 0, 10'h103, 0, 1, 9'd2,   1, 0, 0, 10'h0,   0);
    vt[3]  = mk(1, 0, 0, 0, 10'h104, 0, 1, 9'd3,   1, 0, 0, 10'h0,   0);
    vt[4]  = mk(1, 0, 0, 0, 10'h105, 0, 1, 9'd4,   1, 0, 0, 10'h0,   0);
    vt[5]  = mk(0, 0, 1, 0, 10'h0,   0, 0, 9'd4,   0, 1, 0, 10'h0,   0);
    vt[6]  = mk(0, 0, 0, 0, 10'h0,   0, 0, 9'd4,   0, 0, 1, 10'h101, 0);
    vt[7]  = mk(0, 0, 0, 0, 10'h0,   1, 0, 9'd4,   0, 0, 1, 10'h102, 0);
    vt[8]  = mk(0, 0, 0, 0, 10'h0,   2, 0, 9'd4,   0, 0, 1, 10'h103, 0);
    vt[9]  = mk(0, 0, 0, 0, 10'h0,   3, 0, 9'd4,   0, 0, 1, 10'h104, 0);
    vt[10] = mk(0, 0, 0, 0, 10'h0,   4, 0, 9'd4,   0, 0, 1, 10'h105, 0);
    vt[11] = mk(1, 0, 0, 0, 10'h201, 0, 1, 9'd256, 0, 0, 0, 10'h0,   0);
    vt[12] = mk(1, 0, 0, 0, 10'h202, 0, 1, 9'd257, 0, 0, 0, 10'h0,   0);
    vt[13] = mk(1, 1, 0, 0, 10'h203, 0, 0, 9'd257, 0, 0, 0, 10'h0,   0);
    vt[14] = mk(1, 0, 0, 0, 10'h204, 0, 1, 9'd259, 0, 0, 0, 10'h0,   0);
    vt[15] = mk(1, 0, 0, 0, 10'h205, 0, 1, 9'd260, 0, 0, 0, 10'h0,   0);
    vt[16] = mk(1, 0, 1, 0, 10'h206, 0, 1, 9'd261, 1, 1, 0, 10'h0,  11);
    vt[17] = mk(0, 0, 0, 0, 10'h0,   3, 0, 9'd261, 1, 0, 1, 10'h204,11);
    vt[18] = mk(0, 0, 0, 0, 10'h0,   5, 0, 9'd261, 1, 0, 1, 10'h206,11);
    vt[19] = mk(1, 0, 0, 0, 10'h301, 4, 1, 9'd0,   1, 0, 1, 10'h205,11);
    vt[20] = mk(1, 0, 1, 1, 10'h302, 1, 0, 9'd0,   1, 0, 1, 10'h202,11);
    vt[21] = mk(1, 0, 0, 0, 10'h303, 0, 1, 9'd0,   1, 0, 0, 10'h0,  11);
    vt[22] = mk(0, 0, 0, 0, 10'h0,   0, 0, 9'd0,   1, 0, 1, 10'h201,11);

    repeat (2) @(posedge CLOCK_tb);
    #1;
    chk("rst_we", we, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_rdpage", rd_page, 1);
    chk("rst_lf", line_finished, 0);
    chk("rst_period", line_period, 0);
    chk("rst_rddata", rd_data, 0);
    @(negedge CLOCK_tb);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].pulse, vt[i].err, vt[i].ls, vt[i].fs,
           vt[i].din, vt[i].rd_addr);
      chk($sformatf("v%0d_we", i), we, vt[i].we);
      chk($sformatf("v%0d_addr", i), wr_addr, vt[i].addr);
      chk($sformatf("v%0d_rdpage", i), rd_page, vt[i].rd_page);
      chk($sformatf("v%0d_lf", i), line_finished, vt[i].lf);
      chk($sformatf("v%0d_period", i), line_period, vt[i].per);
      if (vt[i].chk_rd)
        chk($sformatf("v%0d_rd", i), rd_data, vt[i].rd);
    end

    // line period: first sync after frame sync keeps old value
    step(0, 0, 1, 0, 0, 0);
    chk("per_first", line_period, 11);
    chk("per_first_lf", line_finished, 1);
    repeat (999) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("per_second", line_period, 1000);
    repeat (999) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("per_third", line_period, 1000);

    // saturation at end of page
    step(0, 0, 0, 1, 0, 0);
    chk("sat_fs_rdpage", rd_page, 1);
    for (int i = 1; i <= 260; i++) begin
      step(1, 0, 0, 0, 10'(i), 0);
      if (i == 1) chk("sat_first_addr", wr_addr, 0);
      if (i == 256) begin
        chk("sat_last_we", we, 1);
        chk("sat_last_addr", wr_addr, 255);
      end
      if (i > 256) chk($sformatf("sat_ign%0d_we", i), we, 0);
    end
    chk("sat_addr_hold", wr_addr, 255);
    step(0, 0, 1, 0, 0, 0);
    chk("sat_ls_rdpage", rd_page, 0);
    chk("sat_ls_lf", line_finished, 1);
    step(1, 0, 0, 0, 10'h3AA, 8'd255);
    chk("sat_next_we", we, 1);
    chk("sat_next_addr", wr_addr, 256);
    chk("sat_rd255", rd_data, 10'h100);
    chk("sat_period_hold", line_period, 1000);

    // async reset mid-line
    step(1, 0, 0, 0, 10'h011, 0);
    chk("mid_addr", wr_addr, 257);
    @(negedge CLOCK_tb);
    pulse = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_rdpage", rd_page, 1);
    chk("arst_lf", line_finished, 0);
    chk("arst_period", line_period, 0);
    chk("arst_rddata", rd_data, 0);
    @(negedge CLOCK_tb);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_lf", line_finished, 0);
    step(1, 0, 0, 0, 10'h022, 0);
    chk("post_rst_we", we, 1);
    chk("post_rst_addr", wr_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
